axil_blockmem_1p_ctrl: RTL and testbench

//  AXI4-Lite slave that owns and drives the port of a single-port block memory (1-cycle registered read).

---
 rtl/axil_blockmem_1p_ctrl_if.sv | 43 ++++
 rtl/axil_blockmem_1p_ctrl.sv | 155 +++++++++++++++
 tb/tb_axil_blockmem_1p_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_blockmem_1p_ctrl_if.sv
// AXI4-Lite bus bundle between an interconnect (master) and the
// single-port block-memory controller (slave).
//   s_aw* / s_w* / s_b* : write address, write data and write response channels
//   s_ar* / s_r*        : read address and read data channels
// Parameters:
//   G_DATAWIDTH : data width in bits (multiple of 8), strobe width is G_DATAWIDTH/8
//   G_AXIADDRW  : byte-address width
interface axil_blockmem_1p_ctrl_if #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_AXIADDRW  = 32
);
  logic [G_AXIADDRW-1:0]    s_awaddr;
  logic                     s_awvalid;
  logic                     s_awready;
  logic [G_DATAWIDTH-1:0]   s_wdata;
  logic [G_DATAWIDTH/8-1:0] s_wstrb;
  logic                     s_wvalid;
  logic                     s_wready;
  logic [1:0]               s_bresp;
  logic                     s_bvalid;
  logic                     s_bready;
  logic [G_AXIADDRW-1:0]    s_araddr;
  logic                     s_arvalid;
  logic                     s_arready;
  logic [G_DATAWIDTH-1:0]   s_rdata;
  logic [1:0]               s_rresp;
  logic                     s_rvalid;
  logic                     s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_blockmem_1p_ctrl.sv
// AXI4-Lite slave owning the single port of a block memory with a 1-cycle
// registered read. Reads and writes are arbitrated round-robin onto the one
// memory port; one transaction is in flight at a time.
// Ports:
//   clka     : clock, everything is synchronous to it
//   resetn   : synchronous reset, active low
//   s        : AXI4-Lite slave bus (axil_blockmem_1p_ctrl_if.slave)
//   mem_en   : memory enable, one cycle per access
//   mem_we   : memory write enable(s), per byte when G_BWENABLE=1
//   mem_addr : memory word address
//   mem_din  : memory write data
//   mem_dout : memory read data, valid the cycle after the mem_en cycle
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for requests, readies driven for the granted channel
// ST_WR    | memory write cycle (mem_en/mem_we active)
// ST_BRESP | write response valid, waiting for bready
// ST_RD    | memory read cycle (mem_en active)
// ST_RCAP  | memory output captured into the read data register
// ST_RRESP | read response valid, waiting for rready
module axil_blockmem_1p_ctrl #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_BWENABLE  = 0,
  parameter int G_AXIADDRW  = 32,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_WEWIDTH   = ((G_DATAWIDTH/8-1)*G_BWENABLE)+1
) (
  input  logic                   clka,
  input  logic                   resetn,
  axil_blockmem_1p_ctrl_if.slave s,
  output logic                   mem_en,
  output logic [G_WEWIDTH-1:0]   mem_we,
  output logic [G_ADDRWIDTH-1:0] mem_addr,
  output logic [G_DATAWIDTH-1:0] mem_din,
  input  logic [G_DATAWIDTH-1:0] mem_dout
);

  localparam int                    C_LSB    = $clog2(G_DATAWIDTH/8);
  localparam logic [G_AXIADDRW-1:0] C_DEPTH  = G_AXIADDRW'(G_MEMDEPTH);
  localparam logic [1:0]            C_OKAY   = 2'b00;
  localparam logic [1:0]            C_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_BRESP, ST_RD, ST_RCAP, ST_RRESP
  } state_t;

  state_t state;
  logic   last_wr;
  logic   wr_err;
  logic   rd_err;

  logic                  wr_req, rd_req, grant_wr, grant_rd;
  logic [G_AXIADDRW-1:0] aw_idx, ar_idx;
  logic                  aw_in_range, ar_in_range;
  logic                  strb_all, strb_none, wr_err_next;
  logic [G_WEWIDTH-1:0]  we_next;

  always_comb begin
    wr_req   = s.s_awvalid & s.s_wvalid;
    rd_req   = s.s_arvalid;
    // On contention the channel not served last wins; a lone request always wins.
    grant_wr = wr_req & (~rd_req | ~last_wr);
    grant_rd = rd_req & (~wr_req | last_wr);

    aw_idx      = s.s_awaddr >> C_LSB;
    ar_idx      = s.s_araddr >> C_LSB;
    aw_in_range = (aw_idx < C_DEPTH);
    ar_in_range = (ar_idx < C_DEPTH);

    strb_all  = &s.s_wstrb;
    strb_none = ~|s.s_wstrb;
    // Without byte enables a partial strobe cannot be honoured, so it is refused.
    wr_err_next = ~aw_in_range | ((G_BWENABLE == 0) & ~strb_all & ~strb_none);

    if (G_BWENABLE != 0) we_next = G_WEWIDTH'(s.s_wstrb);
    else                 we_next = G_WEWIDTH'(strb_all);
    if (wr_err_next) we_next = '0;
  end

  assign s.s_awready = (state == ST_IDLE) & grant_wr;
  assign s.s_wready  = (state == ST_IDLE) & grant_wr;
  assign s.s_arready = (state == ST_IDLE) & grant_rd;

  always_ff @(posedge clka) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      last_wr   <= 1'b0;
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      s.s_bvalid <= 1'b0;
      s.s_bresp  <= C_OKAY;
      s.s_rvalid <= 1'b0;
      s.s_rresp  <= C_OKAY;
      s.s_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            state    <= ST_WR;
            last_wr  <= 1'b1;
            mem_en   <= aw_in_range;
            mem_we   <= we_next;
            mem_addr <= aw_idx[G_ADDRWIDTH-1:0];
            mem_din  <= s.s_wdata;
            wr_err   <= wr_err_next;
          end else if (grant_rd) begin
            state    <= ST_RD;
            last_wr  <= 1'b0;
            mem_en   <= ar_in_range;
            mem_we   <= '0;
            mem_addr <= ar_idx[G_ADDRWIDTH-1:0];
            rd_err   <= ~ar_in_range;
          end
        end
        ST_WR: begin
          mem_en     <= 1'b0;
          mem_we     <= '0;
          s.s_bvalid <= 1'b1;
          s.s_bresp  <= wr_err ? C_SLVERR : C_OKAY;
          state      <= ST_BRESP;
        end
        ST_BRESP: begin
          if (s.s_bready) begin
            s.s_bvalid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_RD: begin
          mem_en <= 1'b0;
          state  <= ST_RCAP;
        end
        ST_RCAP: begin
          s.s_rdata  <= rd_err ? '0 : mem_dout;
          s.s_rresp  <= rd_err ? C_SLVERR : C_OKAY;
          s.s_rvalid <= 1'b1;
          state      <= ST_RRESP;
        end
        ST_RRESP: begin
          if (s.s_rready) begin
            s.s_rvalid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_blockmem_1p_ctrl.sv
// Directed bench for axil_blockmem_1p_ctrl. Two instances: dut0 with whole-word
// write enable and dut1 with byte enables; sel_bw routes the shared stimulus.
module tb_axil_blockmem_1p_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sel_bw = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

  axil_blockmem_1p_ctrl_if #(.G_DATAWIDTH(32), .G_AXIADDRW(32)) bus0 ();
  axil_blockmem_1p_ctrl_if #(.G_DATAWIDTH(32), .G_AXIADDRW(32)) bus1 ();

  assign bus0.s_awaddr  = awaddr;
  assign bus0.s_wdata   = wdata;
  assign bus0.s_wstrb   = wstrb;
  assign bus0.s_araddr  = araddr;
  assign bus0.s_awvalid = awvalid & ~sel_bw;
  assign bus0.s_wvalid  = wvalid & ~sel_bw;
  assign bus0.s_arvalid = arvalid & ~sel_bw;
  assign bus0.s_bready  = bready;
  assign bus0.s_rready  = rready;
  assign bus1.s_awaddr  = awaddr;
  assign bus1.s_wdata   = wdata;
  assign bus1.s_wstrb   = wstrb;
  assign bus1.s_araddr  = araddr;
  assign bus1.s_awvalid = awvalid & sel_bw;
  assign bus1.s_wvalid  = wvalid & sel_bw;
  assign bus1.s_arvalid = arvalid & sel_bw;
  assign bus1.s_bready  = bready;
  assign bus1.s_rready  = rready;

  logic        m0_en, m1_en;
  logic [0:0]  m0_we;
  logic [3:0]  m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_din, m1_din, m0_dout, m1_dout;

  axil_blockmem_1p_ctrl #(.G_BWENABLE(0)) dut0 (
    .clka(clk), .resetn(resetn), .s(bus0),
    .mem_en(m0_en), .mem_we(m0_we), .mem_addr(m0_addr), .mem_din(m0_din), .mem_dout(m0_dout)
  );
  axil_blockmem_1p_ctrl #(.G_BWENABLE(1)) dut1 (
    .clka(clk), .resetn(resetn), .s(bus1),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_din(m1_din), .mem_dout(m1_dout)
  );

  // Block memory models: registered read, read-before-write.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  always @(posedge clk) begin
    if (m0_en) begin
      if (m0_we[0]) mem0[m0_addr] <= m0_din;
      m0_dout <= mem0[m0_addr];
    end
    if (m1_en) begin
      for (int b = 0; b < 4; b++)
        if (m1_we[b]) mem1[m1_addr][8*b +: 8] <= m1_din[8*b +: 8];
      m1_dout <= mem1[m1_addr];
    end
  end

  wire        o_awready = sel_bw ? bus1.s_awready : bus0.s_awready;
  wire        o_wready  = sel_bw ? bus1.s_wready  : bus0.s_wready;
  wire        o_arready = sel_bw ? bus1.s_arready : bus0.s_arready;
  wire        o_bvalid  = sel_bw ? bus1.s_bvalid  : bus0.s_bvalid;
  wire [1:0]  o_bresp   = sel_bw ? bus1.s_bresp   : bus0.s_bresp;
  wire        o_rvalid  = sel_bw ? bus1.s_rvalid  : bus0.s_rvalid;
  wire [1:0]  o_rresp   = sel_bw ? bus1.s_rresp   : bus0.s_rresp;
  wire [31:0] o_rdata   = sel_bw ? bus1.s_rdata   : bus0.s_rdata;
  wire        o_en      = sel_bw ? m1_en   : m0_en;
  wire [3:0]  o_we      = sel_bw ? m1_we   : {3'b000, m0_we};
  wire [9:0]  o_addr    = sel_bw ? m1_addr : m0_addr;
  wire [31:0] o_din     = sel_bw ? m1_din  : m0_din;

  // Write transaction with bready high; samples T+1 memory signals and T+2 response.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           output bit ok, output logic en1, output logic [3:0] we1,
                           output logic [9:0] ad1, output logic [31:0] din1,
                           output logic bv1, output logic bv2, output logic [1:0] br2);
    ok = 0; en1 = 0; we1 = 0; ad1 = 0; din1 = 0; bv1 = 0; bv2 = 0; br2 = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = st; awvalid = 1; wvalid = 1; bready = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_awready && o_wready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin awvalid = 0; wvalid = 0; return; end
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    en1 = o_en; we1 = o_we; ad1 = o_addr; din1 = o_din; bv1 = o_bvalid;
    @(negedge clk);
    bv2 = o_bvalid; br2 = o_bresp;
    @(posedge clk);
  endtask

  // Read transaction with rready high; samples T+1 memory signals, T+2 and T+3 response.
  task automatic read_txn(input logic [31:0] a, output bit ok, output logic en1,
                          output logic [3:0] we1, output logic [9:0] ad1, output logic rv2,
                          output logic rv3, output logic [31:0] rd3, output logic [1:0] rr3);
    ok = 0; en1 = 0; we1 = 0; ad1 = 0; rv2 = 0; rv3 = 0; rd3 = 0; rr3 = 0;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_arready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin arvalid = 0; return; end
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    en1 = o_en; we1 = o_we; ad1 = o_addr;
    @(negedge clk);
    rv2 = o_rvalid;
    @(negedge clk);
    rv3 = o_rvalid; rd3 = o_rdata; rr3 = o_rresp;
    @(posedge clk);
  endtask

  bit ok;
  logic en1, bv1, bv2, rv2, rv3;
  logic [3:0] we1;
  logic [9:0] ad1;
  logic [31:0] din1, rd3;
  logic [1:0] br2, rr3;

  task automatic test_reset();
    resetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    checks++; if (o_bvalid !== 1'b0 || o_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_valids got b=%b r=%b exp 0 0", o_bvalid, o_rvalid); end
    checks++; if (o_en !== 1'b0 || o_we !== 4'h0) begin errors++;
      $display("FAIL reset_mem got en=%b we=%h exp 0 0", o_en, o_we); end
    checks++; if (o_rdata !== 32'h0 || o_bresp !== 2'b00 || o_rresp !== 2'b00) begin errors++;
      $display("FAIL reset_data got rdata=%h bresp=%b rresp=%b exp 0", o_rdata, o_bresp, o_rresp); end
    checks++; if (o_awready !== 1'b0 || o_arready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got aw=%b ar=%b exp 0 0", o_awready, o_arready); end
  endtask

  task automatic test_write_read();
    write_txn(32'h10, 32'hDEADBEEF, 4'hF, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr1_handshake got %b exp 1", ok); end
    checks++; if ({en1, we1, ad1} !== {1'b1, 4'h1, 10'd4}) begin errors++;
      $display("FAIL wr1_mem got en=%b we=%h addr=%0d exp 1 1 4", en1, we1, ad1); end
    checks++; if (din1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr1_din got %h exp deadbeef", din1); end
    checks++; if ({bv1, bv2, br2} !== {1'b0, 1'b1, 2'b00}) begin errors++;
      $display("FAIL wr1_bresp got bv1=%b bv2=%b bresp=%b exp 0 1 00", bv1, bv2, br2); end
    read_txn(32'h10, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({ok, en1, we1, ad1} !== {1'b1, 1'b1, 4'h0, 10'd4}) begin errors++;
      $display("FAIL rd1_mem got ok=%b en=%b we=%h addr=%0d exp 1 1 0 4", ok, en1, we1, ad1); end
    checks++; if ({rv2, rv3, rr3} !== {1'b0, 1'b1, 2'b00}) begin errors++;
      $display("FAIL rd1_timing got rv2=%b rv3=%b rresp=%b exp 0 1 00", rv2, rv3, rr3); end
    checks++; if (rd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd1_data got %h exp deadbeef", rd3); end
  endtask

  task automatic test_partial_strobe();
    write_txn(32'h10, 32'h55555555, 4'h3, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({ok, we1, bv2, br2} !== {1'b1, 4'h0, 1'b1, 2'b10}) begin errors++;
      $display("FAIL partial_strb got ok=%b we=%h bv=%b bresp=%b exp 1 0 1 10", ok, we1, bv2, br2); end
    write_txn(32'h10, 32'h12345678, 4'h0, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({ok, we1, bv2, br2} !== {1'b1, 4'h0, 1'b1, 2'b00}) begin errors++;
      $display("FAIL zero_strb got ok=%b we=%h bv=%b bresp=%b exp 1 0 1 00", ok, we1, bv2, br2); end
    read_txn(32'h10, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({rd3, rr3} !== {32'hDEADBEEF, 2'b00}) begin errors++;
      $display("FAIL partial_readback got %h/%b exp deadbeef/00", rd3, rr3); end
  endtask

  task automatic test_out_of_range();
    write_txn(32'h0, 32'hCAFEF00D, 4'hF, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({ok, br2} !== {1'b1, 2'b00}) begin errors++; $display("FAIL oor_pre got ok=%b bresp=%b exp 1 00", ok, br2); end
    write_txn(32'h1000, 32'hBAD0BAD0, 4'hF, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({ok, en1, we1, bv2, br2} !== {1'b1, 1'b0, 4'h0, 1'b1, 2'b10}) begin errors++;
      $display("FAIL oor_write got ok=%b en=%b we=%h bv=%b bresp=%b exp 1 0 0 1 10", ok, en1, we1, bv2, br2); end
    read_txn(32'h1000, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({ok, en1, rv3, rd3, rr3} !== {1'b1, 1'b0, 1'b1, 32'h0, 2'b10}) begin errors++;
      $display("FAIL oor_read got ok=%b en=%b rv=%b rdata=%h rresp=%b exp 1 0 1 0 10", ok, en1, rv3, rd3, rr3); end
    read_txn(32'h3, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({ad1, rd3, rr3} !== {10'd0, 32'hCAFEF00D, 2'b00}) begin errors++;
      $display("FAIL unaligned_read got addr=%0d rdata=%h rresp=%b exp 0 cafef00d 00", ad1, rd3, rr3); end
    write_txn(32'hFFC, 32'h0BADCAFE, 4'hF, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({en1, ad1, br2} !== {1'b1, 10'd1023, 2'b00}) begin errors++;
      $display("FAIL last_word_wr got en=%b addr=%0d bresp=%b exp 1 1023 00", en1, ad1, br2); end
    read_txn(32'hFFC, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({rd3, rr3} !== {32'h0BADCAFE, 2'b00}) begin errors++;
      $display("FAIL last_word_rd got %h/%b exp 0badcafe/00", rd3, rr3); end
  endtask

  task automatic test_byte_enable();
    sel_bw = 1;
    write_txn(32'h20, 32'h11223344, 4'hF, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({ok, en1, we1, ad1, br2} !== {1'b1, 1'b1, 4'hF, 10'd8, 2'b00}) begin errors++;
      $display("FAIL bw_full got ok=%b en=%b we=%h addr=%0d bresp=%b exp 1 1 f 8 00", ok, en1, we1, ad1, br2); end
    write_txn(32'h20, 32'h0000AA00, 4'h2, ok, en1, we1, ad1, din1, bv1, bv2, br2);
    checks++; if ({ok, we1, br2} !== {1'b1, 4'h2, 2'b00}) begin errors++;
      $display("FAIL bw_partial got ok=%b we=%h bresp=%b exp 1 2 00", ok, we1, br2); end
    read_txn(32'h20, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({ok, rd3, rr3} !== {1'b1, 32'h1122AA44, 2'b00}) begin errors++;
      $display("FAIL bw_readback got ok=%b rdata=%h rresp=%b exp 1 1122aa44 00", ok, rd3, rr3); end
    sel_bw = 0;
  endtask

  task automatic test_arbitration();
    bit g [6];
    logic [31:0] rd [3];
    bit exp_g [6];
    int n = 0, wi = 0, ri = 0, rc = 0;
    bit gw, gr, done = 0;
    exp_g = '{1, 0, 1, 0, 1, 0};
    @(negedge clk);
    awaddr = 32'h100; wdata = 32'hA0000000; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h100; arvalid = 1; bready = 1; rready = 1;
    for (int c = 0; c < 80; c++) begin
      if (wi == 3 && ri == 3 && rc == 3) begin done = 1; break; end
      #1;
      gw = o_awready & o_wready & awvalid;
      gr = o_arready & arvalid;
      if (gw && n < 6) begin g[n] = 1; n++; end
      if (gr && n < 6) begin g[n] = 0; n++; end
      if (o_rvalid && rc < 3) begin rd[rc] = o_rdata; rc++; end
      @(posedge clk);
      #1;
      if (gw) begin
        wi++;
        if (wi < 3) begin awaddr = 32'h100 + 32'(4 * wi); wdata = 32'hA0000000 + 32'(wi); end
        else begin awvalid = 0; wvalid = 0; end
      end
      if (gr) begin
        ri++;
        if (ri < 3) araddr = 32'h100 + 32'(4 * ri);
        else arvalid = 0;
      end
      @(negedge clk);
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++; if ({done, n} !== {1'b1, 32'd6}) begin errors++;
      $display("FAIL arb_complete got done=%b grants=%0d exp 1 6", done, n); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (g[k] !== exp_g[k]) begin errors++;
        $display("FAIL arb_grant%0d got wr=%b exp %b", k, g[k], exp_g[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd[k] !== 32'hA0000000 + 32'(k)) begin errors++;
        $display("FAIL arb_rdata%0d got %h exp %h", k, rd[k], 32'hA0000000 + 32'(k)); end
    end
  endtask

  task automatic test_back_pressure();
    bit hold_ok = 1, got = 0;
    @(negedge clk);
    awaddr = 32'h40; wdata = 32'h77665544; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    for (int i = 0; i < 20; i++) begin #1; if (o_awready) begin got = 1; break; end @(negedge clk); end
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 32'h40; arvalid = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (o_bvalid !== 1'b1 || o_bresp !== 2'b00 || o_arready !== 1'b0 || o_awready !== 1'b0) hold_ok = 0;
    end
    checks++; if ({got, hold_ok} !== 2'b11) begin errors++;
      $display("FAIL bresp_hold got hs=%b stable=%b exp 1 1", got, hold_ok); end
    bready = 1;
    @(posedge clk);
    got = 0; hold_ok = 1; rready = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (o_arready) begin got = 1; break; end end
    @(posedge clk);
    @(negedge clk);
    araddr = 32'h44;
    for (int i = 0; i < 20; i++) begin if (o_rvalid) break; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (o_rvalid !== 1'b1 || o_rdata !== 32'h77665544 || o_rresp !== 2'b00 || o_arready !== 1'b0) hold_ok = 0;
    end
    checks++; if ({got, hold_ok} !== 2'b11) begin errors++;
      $display("FAIL rresp_hold got hs=%b stable=%b exp 1 1", got, hold_ok); end
    arvalid = 0; rready = 1;
    @(posedge clk);
    // Read aborted by reset while in the capture state.
    @(negedge clk);
    araddr = 32'h40; arvalid = 1; got = 0;
    for (int i = 0; i < 20; i++) begin #1; if (o_arready) begin got = 1; break; end @(negedge clk); end
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    checks++; if ({got, o_rvalid, o_en} !== {1'b1, 1'b0, 1'b0}) begin errors++;
      $display("FAIL rcap_reset got hs=%b rvalid=%b en=%b exp 1 0 0", got, o_rvalid, o_en); end
    resetn = 1;
    @(negedge clk);
    checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid got %b exp 0", o_rvalid); end
    read_txn(32'h40, ok, en1, we1, ad1, rv2, rv3, rd3, rr3);
    checks++; if ({ok, rv3, rd3, rr3} !== {1'b1, 1'b1, 32'h77665544, 2'b00}) begin errors++;
      $display("FAIL post_reset_read got ok=%b rv=%b rdata=%h rresp=%b exp 1 1 77665544 00", ok, rv3, rd3, rr3); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_byte_enable();
    test_arbitration();
    test_back_pressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
